// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS payload, optional odd/even parity,
// 1 or 2 stop bits. Each bit is decided by a 3-sample majority around mid-bit.
// Reports parity, framing and break conditions alongside each received word.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int M  = (CLKS_PER_BIT - 1) / 2;

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_S0   = TW'(M - 1);
  localparam logic [TW-1:0] T_S1   = TW'(M);
  localparam logic [TW-1:0] T_DEC  = TW'(M + 1);
  localparam logic [BW-1:0] B_LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_LAST_STOP = BW'(STOP_BITS - 1);

  // Reject parameter values the datapath was not built for.
  if (CLKS_PER_BIT < 8) begin : g_bad_cpb
    $error("uart_rx_cfg: CLKS_PER_BIT must be >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                r_State;
  state_t                w_Next;
  logic                  r_Rx_Meta, r_Rx_Sync;
  logic [TW-1:0]         r_Timer;
  logic [BW-1:0]         r_BitIdx;
  logic                  r_Smp0, r_Smp1;
  logic [DATA_BITS-1:0]  r_Shift;
  logic                  r_Perr, r_Ferr, r_AllZero;
  logic                  r_DV, r_PErrO, r_FErrO, r_BreakO, r_Busy;
  logic [DATA_BITS-1:0]  r_Byte;
  logic                  w_S, w_BitEnd, w_Decide, w_Maj, w_ExpPar, w_Done;

  assign w_S      = r_Rx_Sync;
  assign w_BitEnd = (r_Timer == T_LAST);
  assign w_Decide = (r_Timer == T_DEC);
  // Third sample is the live synchronised value at the decision cycle.
  assign w_Maj    = (r_Smp0 & r_Smp1) | (r_Smp0 & w_S) | (r_Smp1 & w_S);
  assign w_ExpPar = (PARITY == 1) ? ~(^r_Shift) : (^r_Shift);

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Rx_Meta <= 1'b1;
      r_Rx_Sync <= 1'b1;
    end else begin
      r_Rx_Meta <= i_Rx_Serial;
      r_Rx_Sync <= r_Rx_Meta;
    end
  end

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_State <= S_WAIT_IDLE;
    else         r_State <= w_Next;
  end

  // Next-state logic; the last stop bit finishes at its decision point so a
  // following start edge is never missed.
  always_comb begin
    w_Next = r_State;
    w_Done = 1'b0;
    case (r_State)
      S_WAIT_IDLE: if (w_S) w_Next = S_IDLE;
      S_IDLE:      if (!w_S) w_Next = S_START;
      S_START: begin
        if (w_Decide && w_Maj) w_Next = S_IDLE;
        else if (w_BitEnd)     w_Next = S_DATA;
      end
      S_DATA: begin
        if (w_BitEnd && r_BitIdx == B_LAST_DATA)
          w_Next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_BitEnd) w_Next = S_STOP;
      S_STOP: begin
        if (w_Decide && r_BitIdx == B_LAST_STOP) begin
          w_Done = 1'b1;
          w_Next = (r_Ferr || !w_Maj) ? S_WAIT_IDLE : S_IDLE;
        end
      end
      default: w_Next = S_WAIT_IDLE;
    endcase
  end

  // Bit timer and bit counter; both restart on every state change.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Timer  <= '0;
      r_BitIdx <= '0;
    end else begin
      if (r_State == S_IDLE || r_State == S_WAIT_IDLE || w_Next == S_IDLE ||
          w_Next == S_WAIT_IDLE || w_BitEnd)
        r_Timer <= '0;
      else
        r_Timer <= r_Timer + 1'b1;
      if (w_Next != r_State)
        r_BitIdx <= '0;
      else if (w_BitEnd && (r_State == S_DATA || r_State == S_STOP))
        r_BitIdx <= r_BitIdx + 1'b1;
    end
  end

  // Mid-bit sampling, payload shift and error tracking.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Smp0    <= 1'b1;
      r_Smp1    <= 1'b1;
      r_Shift   <= '0;
      r_Perr    <= 1'b0;
      r_Ferr    <= 1'b0;
      r_AllZero <= 1'b1;
    end else begin
      if (r_Timer == T_S0) r_Smp0 <= w_S;
      if (r_Timer == T_S1) r_Smp1 <= w_S;
      if (r_State == S_IDLE && !w_S) begin
        r_Perr    <= 1'b0;
        r_Ferr    <= 1'b0;
        r_AllZero <= 1'b1;
      end
      if (w_Decide) begin
        case (r_State)
          S_DATA: begin
            r_Shift   <= {w_Maj, r_Shift[DATA_BITS-1:1]};
            r_AllZero <= r_AllZero & ~w_Maj;
          end
          S_PARITY: begin
            if (w_Maj != w_ExpPar) r_Perr <= 1'b1;
            r_AllZero <= r_AllZero & ~w_Maj;
          end
          S_STOP: begin
            if (!w_Maj) r_Ferr <= 1'b1;
            r_AllZero <= r_AllZero & ~w_Maj;
          end
          default: ;
        endcase
      end
    end
  end

  // Output registers: word and flags latch on completion and hold.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_DV     <= 1'b0;
      r_Byte   <= '0;
      r_PErrO  <= 1'b0;
      r_FErrO  <= 1'b0;
      r_BreakO <= 1'b0;
      r_Busy   <= 1'b0;
    end else begin
      r_DV   <= w_Done;
      r_Busy <= (w_Next != S_IDLE);
      if (w_Done) begin
        r_Byte   <= r_Shift;
        r_PErrO  <= r_Perr;
        r_FErrO  <= r_Ferr | ~w_Maj;
        r_BreakO <= r_AllZero & ~w_Maj;
      end
    end
  end

  assign o_Rx_DV      = r_DV;
  assign o_Rx_Byte    = r_Byte;
  assign o_Parity_Err = r_PErrO;
  assign o_Frame_Err  = r_FErrO;
  assign o_Break      = r_BreakO;
  assign o_Busy       = r_Busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 16
// clocks per bit share clock and reset; each has its own serial line.
module tb_uart_rx_cfg;
  localparam int CPB = 16;
  localparam int M   = (CPB - 1) / 2;
  // 8N1: start + 8 data bits precede the (only) stop bit.
  localparam int LAT_8N1 = 2 + 1 + (1 + 8 + 0 + 1 - 1) * CPB + M + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic dv_a, dv_b, dv_c;
  logic [7:0] byte_a, byte_c;
  logic [6:0] byte_b;
  logic pe_a, fe_a, brk_a, busy_a;
  logic pe_b, fe_b, brk_b, busy_b;
  logic pe_c, fe_c, brk_c, busy_c;

  int checks = 0, errors = 0;
  int cyc = 0;
  int n_a = 0, n_b = 0, n_c = 0, long_dv = 0, lcyc_a = 0;
  logic pdv_a = 1'b0, pdv_b = 1'b0, pdv_c = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .o_Rx_DV(dv_a),
    .o_Rx_Byte(byte_a), .o_Parity_Err(pe_a), .o_Frame_Err(fe_a),
    .o_Break(brk_a), .o_Busy(busy_a));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .o_Rx_DV(dv_b),
    .o_Rx_Byte(byte_b), .o_Parity_Err(pe_b), .o_Frame_Err(fe_b),
    .o_Break(brk_b), .o_Busy(busy_b));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_c (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_c), .o_Rx_DV(dv_c),
    .o_Rx_Byte(byte_c), .o_Parity_Err(pe_c), .o_Frame_Err(fe_c),
    .o_Break(brk_c), .o_Busy(busy_c));

  always @(posedge clk) cyc <= cyc + 1;

  // Count DV pulses and flag any pulse longer than one cycle.
  always @(negedge clk) begin
    pdv_a <= dv_a; pdv_b <= dv_b; pdv_c <= dv_c;
    if ((dv_a && pdv_a) || (dv_b && pdv_b) || (dv_c && pdv_c)) long_dv <= long_dv + 1;
    if (dv_a) begin n_a <= n_a + 1; lcyc_a <= cyc; end
    if (dv_b) n_b <= n_b + 1;
    if (dv_c) n_c <= n_c + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int ln, input logic v);
    case (ln)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_bit(input int ln, input logic v);
    set_line(ln, v);
    tick(CPB);
  endtask

  // Start bit, nb data bits LSB first, optional parity (pm 1=odd 2=even,
  // pforce overrides with pval), then ns stop bits taken from stp.
  task automatic send_frame(input int ln, input int nb, input logic [8:0] d,
                            input int pm, input logic pforce, input logic pval,
                            input int ns, input logic [1:0] stp, output int c0);
    logic p;
    c0 = cyc;
    send_bit(ln, 1'b0);
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      send_bit(ln, d[i]);
      p = p ^ d[i];
    end
    if (pm != 0) begin
      if (pm == 1) p = ~p;
      if (pforce) p = pval;
      send_bit(ln, p);
    end
    for (int i = 0; i < ns; i++) send_bit(ln, stp[i]);
  endtask

  initial begin
    int c0, n0;
    // Reset with idle line.
    tick(4);
    chk("rst_dv",   32'(dv_a),   32'h0);
    chk("rst_byte", 32'(byte_a), 32'h0);
    chk("rst_flags", {29'd0, pe_a, fe_a, brk_a}, 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    rst = 1'b0;
    tick(3);
    chk("idle_busy", 32'(busy_a), 32'h0);

    // 8N1 0xA5 with latency measured from the falling edge.
    send_frame(0, 8, 9'h0A5, 0, 1'b0, 1'b0, 1, 2'b11, c0);
    tick(2);
    chk("t1_count", 32'(n_a), 32'd1);
    chk("t1_byte",  32'(byte_a), 32'hA5);
    chk("t1_flags", {29'd0, pe_a, fe_a, brk_a}, 32'h0);
    chk("t1_lat",   32'(lcyc_a - c0), 32'(LAT_8N1));

    // 7E1 0x35: correct parity (0), then forced wrong parity (1).
    send_frame(1, 7, 9'h035, 2, 1'b0, 1'b0, 1, 2'b11, c0);
    tick(2);
    chk("t2_byte_ok", 32'(byte_b), 32'h35);
    chk("t2_perr_ok", 32'(pe_b), 32'h0);
    send_frame(1, 7, 9'h035, 2, 1'b1, 1'b1, 1, 2'b11, c0);
    tick(2);
    chk("t2_byte_bad", 32'(byte_b), 32'h35);
    chk("t2_perr_bad", 32'(pe_b), 32'h1);
    chk("t2_ferr_bad", 32'(fe_b), 32'h0);
    chk("t2_count", 32'(n_b), 32'd2);

    // 8N2 0x3C with second stop low: framing error, then wait for idle.
    send_frame(2, 8, 9'h03C, 0, 1'b0, 1'b0, 2, 2'b01, c0);
    chk("t3_byte", 32'(byte_c), 32'h3C);
    chk("t3_ferr", 32'(fe_c), 32'h1);
    chk("t3_brk",  32'(brk_c), 32'h0);
    chk("t3_busy_low", 32'(busy_c), 32'h1);
    tick(3 * CPB);
    chk("t3_busy_hold", 32'(busy_c), 32'h1);
    chk("t3_count1", 32'(n_c), 32'd1);
    rx_c = 1'b1;
    tick(CPB);
    chk("t3_busy_idle", 32'(busy_c), 32'h0);
    send_frame(2, 8, 9'h001, 0, 1'b0, 1'b0, 2, 2'b11, c0);
    tick(2);
    chk("t3_byte2", 32'(byte_c), 32'h01);
    chk("t3_flags2", {29'd0, pe_c, fe_c, brk_c}, 32'h0);
    chk("t3_count2", 32'(n_c), 32'd2);

    // Break: line low for two frame times.
    n0 = n_a;
    rx_a = 1'b0;
    tick(2 * 10 * CPB);
    chk("t4_count", 32'(n_a - n0), 32'd1);
    chk("t4_byte",  32'(byte_a), 32'h00);
    chk("t4_brk",   32'(brk_a), 32'h1);
    chk("t4_ferr",  32'(fe_a), 32'h1);
    chk("t4_busy",  32'(busy_a), 32'h1);
    rx_a = 1'b1;
    tick(CPB);
    chk("t4_idle", 32'(busy_a), 32'h0);
    send_frame(0, 8, 9'h05A, 0, 1'b0, 1'b0, 1, 2'b11, c0);
    tick(2);
    chk("t4_byte2", 32'(byte_a), 32'h5A);
    chk("t4_flags2", {29'd0, pe_a, fe_a, brk_a}, 32'h0);

    // Glitches on an idle line: 1-cycle low, then low only for sample 0.
    n0 = n_a;
    rx_a = 1'b0; tick(1); rx_a = 1'b1;
    tick(3 * CPB);
    chk("t5_g1_count", 32'(n_a - n0), 32'd0);
    chk("t5_g1_busy", 32'(busy_a), 32'h0);
    rx_a = 1'b0; tick(M + 1); rx_a = 1'b1;
    tick(2);
    chk("t5_g2_start", 32'(busy_a), 32'h1);
    tick(3 * CPB);
    chk("t5_g2_count", 32'(n_a - n0), 32'd0);
    chk("t5_g2_busy", 32'(busy_a), 32'h0);

    // 0x00 with a one-cycle high pulse at the T=M sample of data bit 3.
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b0);
    rx_a = 1'b0; tick(M + 1);
    rx_a = 1'b1; tick(1);
    rx_a = 1'b0; tick(CPB - M - 2);
    for (int i = 4; i < 8; i++) send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    tick(2);
    chk("t5_mid_count", 32'(n_a - n0), 32'd1);
    chk("t5_mid_byte", 32'(byte_a), 32'h00);
    chk("t5_mid_ferr", 32'(fe_a), 32'h0);

    // Back-to-back frames with no idle gap.
    n0 = n_a;
    send_frame(0, 8, 9'h055, 0, 1'b0, 1'b0, 1, 2'b11, c0);
    chk("t6_b2b_byte1", 32'(byte_a), 32'h55);
    send_frame(0, 8, 9'h0AA, 0, 1'b0, 1'b0, 1, 2'b11, c0);
    tick(2);
    chk("t6_b2b_byte2", 32'(byte_a), 32'hAA);
    chk("t6_b2b_count", 32'(n_a - n0), 32'd2);

    // Reset during data bit 4 of 0x0F; frame is abandoned.
    n0 = n_a;
    send_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
    rx_a = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(3);
    chk("t6_rst_dv", 32'(dv_a), 32'h0);
    chk("t6_rst_byte", 32'(byte_a), 32'h00);
    chk("t6_rst_flags", {29'd0, pe_a, fe_a, brk_a}, 32'h0);
    chk("t6_rst_busy", 32'(busy_a), 32'h0);
    rx_a = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10 * CPB);
    chk("t6_rst_nodv", 32'(n_a - n0), 32'd0);
    send_frame(0, 8, 9'h0C3, 0, 1'b0, 1'b0, 1, 2'b11, c0);
    tick(2);
    chk("t6_after_byte", 32'(byte_a), 32'hC3);
    chk("t6_after_flags", {29'd0, pe_a, fe_a, brk_a}, 32'h0);
    chk("t6_after_count", 32'(n_a - n0), 32'd1);

    chk("dv_one_cycle", 32'(long_dv), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
